// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: tracks program run status and cycle budget for the cpu core,
// flags the tohost pass-store and keeps a show-ahead FIFO of store transactions.
module cpu_run_monitor #(
  parameter int          MAX_CYCLES   = 20,
  parameter logic [31:0] END_SENTINEL = 32'h0000_006F,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_0040,
  parameter logic [31:0] PASS_VALUE   = 32'hDEAD_BEEF,
  parameter int          LOG_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_en,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        mem_write,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] wdata,
  output logic [1:0]  state,
  output logic        done,
  output logic        timeout,
  output logic        pass_seen,
  output logic [15:0] cycle_count,
  output logic [31:0] end_pc,
  output logic [7:0]  misalign_cnt,
  output logic [7:0]  drop_cnt,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic [15:0] log_cycle
);
  localparam int AW = $clog2(LOG_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE, TIMEOUT} state_t;
  state_t st;
  logic [AW:0] wr_ptr, rd_ptr, occ;
  logic [31:0] addr_mem [LOG_DEPTH];
  logic [31:0] data_mem [LOG_DEPTH];
  logic [15:0] cyc_mem [LOG_DEPTH];
  logic full, pop, push, accept;
  assign occ = wr_ptr - rd_ptr;
  // occupancy never exceeds LOG_DEPTH, so its top bit alone means full
  assign full = occ[AW];
  assign log_valid = occ != '0;
  assign pop = log_valid && log_ready;
  assign push = st == RUN && run_en && mem_write;
  assign accept = push && (!full || pop);
  assign state = st;
  assign log_addr = log_valid ? addr_mem[rd_ptr[AW-1:0]] : '0;
  assign log_data = log_valid ? data_mem[rd_ptr[AW-1:0]] : '0;
  assign log_cycle = log_valid ? cyc_mem[rd_ptr[AW-1:0]] : '0;
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_mem[wr_ptr[AW-1:0]] <= dmem_addr;
      data_mem[wr_ptr[AW-1:0]] <= wdata;
      cyc_mem[wr_ptr[AW-1:0]] <= cycle_count;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= IDLE;
      done <= 1'b0;
      timeout <= 1'b0;
      pass_seen <= 1'b0;
      cycle_count <= '0;
      end_pc <= '0;
      misalign_cnt <= '0;
      drop_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (accept) wr_ptr <= wr_ptr + (AW+1)'(1);
      case (st)
        IDLE: if (run_en) begin
          st <= RUN;
          done <= 1'b0;
          timeout <= 1'b0;
          pass_seen <= 1'b0;
          cycle_count <= '0;
          end_pc <= '0;
          misalign_cnt <= '0;
          drop_cnt <= '0;
          wr_ptr <= '0;
          rd_ptr <= '0;
        end
        RUN: if (!run_en) st <= IDLE;
        else begin
          if (instr == END_SENTINEL) begin
            st <= DONE;
            done <= 1'b1;
            end_pc <= pc;
          end else if (cycle_count == 16'(MAX_CYCLES - 1)) begin
            st <= TIMEOUT;
            timeout <= 1'b1;
          end else cycle_count <= cycle_count + 16'd1;
          if (mem_write) begin
            if (dmem_addr == TOHOST_ADDR && wdata == PASS_VALUE) pass_seen <= 1'b1;
            if (dmem_addr[1:0] != 2'b00 && misalign_cnt != 8'hFF) misalign_cnt <= misalign_cnt + 8'd1;
            if (full && !pop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          end
        end
        default: if (!run_en) st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: directed checks of run status, budget, pass flag and store-log FIFO.
module tb_cpu_run_monitor;
  logic clk = 1'b0;
  logic reset, run_en, mem_write, log_ready;
  logic [31:0] pc, instr, dmem_addr, wdata;
  logic [1:0] state;
  logic done, timeout, pass_seen, log_valid;
  logic [15:0] cycle_count, log_cycle;
  logic [31:0] end_pc, log_addr, log_data;
  logic [7:0] misalign_cnt, drop_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ea [4];
  logic [31:0] ed [4];
  logic [31:0] ec [4];

  cpu_run_monitor dut (
    .clk(clk), .reset(reset), .run_en(run_en), .pc(pc), .instr(instr),
    .mem_write(mem_write), .dmem_addr(dmem_addr), .wdata(wdata),
    .state(state), .done(done), .timeout(timeout), .pass_seen(pass_seen),
    .cycle_count(cycle_count), .end_pc(end_pc), .misalign_cnt(misalign_cnt),
    .drop_cnt(drop_cnt), .log_valid(log_valid), .log_ready(log_ready),
    .log_addr(log_addr), .log_data(log_data), .log_cycle(log_cycle)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_pass"}, 32'(pass_seen), 0);
    chk({tag, "_cycle"}, 32'(cycle_count), 0);
    chk({tag, "_end_pc"}, end_pc, 0);
    chk({tag, "_misalign"}, 32'(misalign_cnt), 0);
    chk({tag, "_drop"}, 32'(drop_cnt), 0);
    chk({tag, "_log_valid"}, 32'(log_valid), 0);
    chk({tag, "_log_addr"}, log_addr, 0);
    chk({tag, "_log_data"}, log_data, 0);
    chk({tag, "_log_cycle"}, 32'(log_cycle), 0);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [31:0] c);
    chk({tag, "_valid"}, 32'(log_valid), 1);
    chk({tag, "_addr"}, log_addr, a);
    chk({tag, "_data"}, log_data, d);
    chk({tag, "_cycle"}, 32'(log_cycle), c);
  endtask

  initial begin
    reset = 1'b0; run_en = 1'b1; mem_write = 1'b1; log_ready = 1'b0;
    instr = 32'h13; pc = '0; dmem_addr = 32'h40; wdata = 32'hDEAD_BEEF;
    repeat (3) tick();
    chk_zero("rst");

    // sentinel run with a pass store at cycle 3
    reset = 1'b1; mem_write = 1'b0;
    tick();
    chk("a_state_run", 32'(state), 1);
    chk("a_cycle0", 32'(cycle_count), 0);
    for (int k = 0; k < 7; k++) begin
      pc = 32'(4 * k);
      mem_write = (k == 3);
      if (k == 3) chk("a_pre_push_valid", 32'(log_valid), 0);
      tick();
      chk("a_cycle", 32'(cycle_count), 32'(k + 1));
      if (k == 3) begin
        chk("a_pass", 32'(pass_seen), 1);
        chk_head("a_head", 32'h40, 32'hDEAD_BEEF, 3);
      end
    end
    mem_write = 1'b0;
    pc = 32'h1C; instr = 32'h6F;
    tick();
    chk("a_done", 32'(done), 1);
    chk("a_state_done", 32'(state), 2);
    chk("a_end_pc", end_pc, 32'h1C);
    chk("a_cycle_end", 32'(cycle_count), 7);
    chk("a_timeout", 32'(timeout), 0);
    instr = 32'h13; mem_write = 1'b1; dmem_addr = 32'h81;
    for (int i = 0; i < 10; i++) begin
      pc = 32'(100 + i);
      tick();
      chk("a_hold_state", 32'(state), 2);
      chk("a_hold_done", 32'(done), 1);
      chk("a_hold_end_pc", end_pc, 32'h1C);
      chk("a_hold_cycle", 32'(cycle_count), 7);
      chk("a_hold_misalign", 32'(misalign_cnt), 0);
    end
    mem_write = 1'b0; log_ready = 1'b1;
    chk_head("a_drain", 32'h40, 32'hDEAD_BEEF, 3);
    tick();
    chk("a_drained", 32'(log_valid), 0);
    log_ready = 1'b0;

    run_en = 1'b0;
    tick();
    chk("a_idle_state", 32'(state), 0);
    chk("a_idle_done", 32'(done), 1);
    chk("a_idle_end_pc", end_pc, 32'h1C);
    run_en = 1'b1;
    tick();
    chk("r_state", 32'(state), 1);
    chk("r_done_clr", 32'(done), 0);
    chk("r_pass_clr", 32'(pass_seen), 0);
    chk("r_end_pc_clr", end_pc, 0);
    chk("r_cycle_clr", 32'(cycle_count), 0);

    // mid-run reset at cycle 5
    mem_write = 1'b1; dmem_addr = 32'h41;
    for (int k = 0; k < 5; k++) begin
      wdata = 32'(k);
      tick();
    end
    mem_write = 1'b0;
    chk("r_misalign5", 32'(misalign_cnt), 5);
    chk("r_drop1", 32'(drop_cnt), 1);
    chk("r_cycle5", 32'(cycle_count), 5);
    chk_head("r_head", 32'h41, 0, 0);
    reset = 1'b0;
    tick();
    chk_zero("rst_mid");
    reset = 1'b1;
    tick();

    // non-pass stores, misaligned stores, then timeout
    ea[0] = 32'h40; ea[1] = 32'h44; ea[2] = 32'h42; ea[3] = 32'h41;
    ed[0] = 32'h1; ed[1] = 32'hDEAD_BEEF; ed[2] = 32'hA; ed[3] = 32'hB;
    for (int k = 0; k < 4; k++) begin
      mem_write = 1'b1; dmem_addr = ea[k]; wdata = ed[k];
      tick();
    end
    mem_write = 1'b0;
    chk("b_pass", 32'(pass_seen), 0);
    chk("b_misalign", 32'(misalign_cnt), 2);
    chk("b_drop", 32'(drop_cnt), 0);
    log_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_head("b_head", ea[k], ed[k], 32'(k));
      tick();
    end
    chk("b_drained", 32'(log_valid), 0);
    log_ready = 1'b0;
    repeat (11) tick();
    chk("b_cycle19", 32'(cycle_count), 19);
    chk("b_state_run", 32'(state), 1);
    tick();
    chk("b_timeout", 32'(timeout), 1);
    chk("b_state_to", 32'(state), 3);
    chk("b_cycle_to", 32'(cycle_count), 19);
    chk("b_done", 32'(done), 0);
    tick();
    chk("b_hold_timeout", 32'(timeout), 1);
    chk("b_hold_cycle", 32'(cycle_count), 19);

    // sentinel on the last budget cycle wins over timeout
    run_en = 1'b0;
    tick();
    run_en = 1'b1;
    tick();
    chk("c_timeout_clr", 32'(timeout), 0);
    chk("c_state", 32'(state), 1);
    repeat (19) tick();
    instr = 32'h6F; pc = 32'h4C;
    tick();
    instr = 32'h13;
    chk("c_done", 32'(done), 1);
    chk("c_timeout", 32'(timeout), 0);
    chk("c_state", 32'(state), 2);
    chk("c_cycle", 32'(cycle_count), 19);
    chk("c_end_pc", end_pc, 32'h4C);

    // FIFO overflow, ordered drain, then full with simultaneous push and pop
    run_en = 1'b0;
    tick();
    run_en = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      mem_write = 1'b1; dmem_addr = 32'(32'h100 + 4 * k); wdata = 32'(32'h10 + k);
      tick();
    end
    mem_write = 1'b0;
    chk("d_drop2", 32'(drop_cnt), 2);
    log_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_head("d_head", 32'(32'h100 + 4 * i), 32'(32'h10 + i), 32'(i));
      tick();
    end
    chk("d_drained", 32'(log_valid), 0);
    log_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_write = 1'b1; dmem_addr = 32'(32'h200 + 4 * k); wdata = 32'(32'h20 + k);
      tick();
    end
    mem_write = 1'b1; dmem_addr = 32'h300; wdata = 32'h77; log_ready = 1'b1;
    chk_head("d_full_head", 32'h200, 32'h20, 10);
    tick();
    mem_write = 1'b0;
    chk("d_drop_same", 32'(drop_cnt), 2);
    ea[0] = 32'h204; ea[1] = 32'h208; ea[2] = 32'h20C; ea[3] = 32'h300;
    ed[0] = 32'h21; ed[1] = 32'h22; ed[2] = 32'h23; ed[3] = 32'h77;
    ec[0] = 11; ec[1] = 12; ec[2] = 13; ec[3] = 14;
    for (int i = 0; i < 4; i++) begin
      chk_head("d_pp_head", ea[i], ed[i], ec[i]);
      tick();
    end
    chk("d_pp_drained", 32'(log_valid), 0);
    chk("d_cycle", 32'(cycle_count), 19);
    chk("d_state", 32'(state), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
Synthesizable run-status and store-trace unit downstream of the cpu core. It consumes the datapath's fetch stream (pc, instr) and data-memory write bus (mem_write, dmem_addr, wdata). It detects the end-of-program sentinel, enforces a cycle budget and flags the pass-store to the tohost word. It also buffers store transactions in a small FIFO that a host or bench drains through a valid/ready port.

Parameters:
MAX_CYCLES, 20, cycle budget in RUN before TIMEOUT; legal range 1..65535
END_SENTINEL, 32'h0000_006F, instruction word marking program end (jal x0,0)
TOHOST_ADDR, 32'h0000_0040, byte address of the pass/fail word
PASS_VALUE, 32'hDEAD_BEEF, value that signals pass when stored to TOHOST_ADDR
LOG_DEPTH, 4, store-log FIFO entries; power of 2, at least 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
run_en  in  1  high while the core is out of reset and executing
pc  in  32  current PC from datapath
instr  in  32  current instruction from imem
mem_write  in  1  dmem write strobe this cycle
dmem_addr  in  32  dmem byte address
wdata  in  32  store data (rs2)
state  out  2  0=IDLE 1=RUN 2=DONE 3=TIMEOUT
done  out  1  sentinel reached
timeout  out  1  budget exhausted without sentinel
pass_seen  out  1  sticky: PASS_VALUE stored to TOHOST_ADDR
cycle_count  out  16  RUN cycles elapsed
end_pc  out  32  PC of the sentinel instruction
misalign_cnt  out  8  stores with dmem_addr[1:0]!=0, saturating
drop_cnt  out  8  stores lost to a full FIFO, saturating
log_valid  out  1  FIFO head valid
log_ready  in  1  consumer accepts head
log_addr  out  32  head store address
log_data  out  32  head store data
log_cycle  out  16  cycle_count at capture of head

Behaviour:
- reset==0 at posedge: state=IDLE. All outputs 0, FIFO emptied. Overrides every other event, including mid-RUN.
- IDLE: nothing is counted or captured. When run_en=1, go to RUN and clear cycle_count, pass_seen, end_pc, misalign_cnt, drop_cnt and the FIFO. Status holds while in IDLE so it stays readable after a run.
- RUN, each cycle:
  - cycle_count is the index of the current cycle; the first RUN cycle is 0. It increments at posedge.
  - instr==END_SENTINEL: next state DONE, done=1, end_pc<=pc, cycle_count frozen at that index.
  - Otherwise, cycle_count==MAX_CYCLES-1: next state TIMEOUT, timeout=1, cycle_count frozen.
  - Sentinel takes priority over timeout in the same cycle.
- Store capture happens only in RUN cycles with mem_write=1, including the sentinel or timeout cycle:
  - dmem_addr==TOHOST_ADDR && wdata==PASS_VALUE: pass_seen<=1.
  - dmem_addr[1:0]!=0: misalign_cnt++ (saturate at 255). The store is still logged.
  - Push {dmem_addr, wdata, cycle_count} into the FIFO.
- DONE and TIMEOUT are terminal. No counting, no capture, flags hold.
- run_en=0 in any non-IDLE state: go to IDLE next cycle with status held. done and timeout remain set until the next IDLE->RUN entry.
- FIFO:
  - Show-ahead: log_* reflect the head whenever log_valid=1.
  - Pop occurs at posedge when log_valid && log_ready.
  - Push is accepted if occupancy<LOG_DEPTH, or if a pop happens in the same cycle (full with simultaneous push and pop: both occur, occupancy stays LOG_DEPTH).
  - Push to a full FIFO with no pop: entry dropped, drop_cnt++ (saturate at 255).
  - Push to an empty FIFO: log_valid=1 the cycle after the push edge (1-cycle latency).
  - Draining is allowed in every state, including IDLE.
  - Read/write pointers wrap modulo LOG_DEPTH; occupancy tracked with one extra bit.
  - log_* outputs are 0 when the FIFO is empty.
- Latency: every flag or counter update is visible the cycle after the triggering posedge. No combinational input-to-output paths except log_* following FIFO state.

Test Plan:
- Reset: reset=0 for 3 cycles with run_en=1 and mem_write=1 -> state=0, every output 0, log_valid=0. Asserting reset mid-RUN at cycle 5 -> same result next cycle.
- Sentinel: run_en=1; instr=0x00000013 for cycles 0-6, then instr=0x0000006F with pc=0x1C at cycle 7 -> done=1, state=2, end_pc=0x1C, cycle_count=7, all held for 10 further cycles.
- Timeout: MAX_CYCLES=20, sentinel never presented -> timeout=1, state=3, cycle_count=19, done=0. Sentinel and timeout in the same cycle (sentinel at cycle 19) -> done=1, timeout=0.
- Pass store: store addr 0x40 data 0xDEADBEEF at cycle 3 -> pass_seen=1 from cycle 4, log entry {0x40, 0xDEADBEEF, 3}. A store of 0x1 to 0x40, or 0xDEADBEEF to 0x44 -> pass_seen stays 0.
- Misalign: stores to 0x42 and 0x41 -> misalign_cnt=2, both entries logged in order with correct addr, data and cycle.
- FIFO full: LOG_DEPTH=4, log_ready=0, 6 stores -> 4 entries held, drop_cnt=2. Then log_ready=1 -> the first 4 stores drain in order, log_valid falls after the 4th pop. With the FIFO full, a push and pop in the same cycle -> push accepted, drop_cnt unchanged.
